spi_frame_seq: RTL and testbench
================================

SPI_FRAME_SEQ -- requirements
Module: spi_frame_seq

Interface
REQ-001 The block SHALL have parameter NBYTES, default 8, giving the number of data bytes per frame (legal range 1..16).
REQ-002 The block SHALL have parameter CMD_BYTE, default 8'h40, giving the first byte of every frame.
REQ-003 The block SHALL have parameter ADDR_BYTE, default 8'hC0, giving the second byte of every frame.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 buf_we  input  1  write strobe for the internal frame buffer.
REQ-007 buf_addr  input  4  frame buffer index.
REQ-008 buf_wdata  input  8  frame buffer write data.
REQ-009 start  input  1  one-cycle request to emit one frame.
REQ-010 full  input  1  full flag of the downstream SPI FIFO.
REQ-011 write  output  1  push strobe to the downstream FIFO.
REQ-012 data  output  8  byte to push; valid whenever write=1.
REQ-013 busy  output  1  high from frame acceptance until the last byte is pushed.
REQ-014 done  output  1  one-cycle pulse after the last byte of a frame is pushed.
REQ-015 buf_err  output  1  one-cycle pulse flagging a rejected buffer write.

Function
REQ-016 The frame buffer SHALL hold NBYTES registered bytes, written on a rising edge when buf_we=1, buf_addr<NBYTES and busy=0.
REQ-017 A buffer write with busy=1 or buf_addr>=NBYTES SHALL be dropped, and buf_err SHALL pulse high for the following cycle.
REQ-018 The FSM SHALL have states IDLE, CMD, ADDR, DATA and CSUM (CSUM exists only per REQ-031).
REQ-019 In IDLE, start=1 SHALL move the FSM to CMD and set busy=1 on the same edge; start in any other state SHALL be ignored.
REQ-020 write SHALL be combinational: it equals (state is not IDLE) AND NOT full.
REQ-021 A byte SHALL count as pushed on each rising edge where write=1; the FSM SHALL advance only on pushed bytes and hold while full=1.
REQ-022 data SHALL be CMD_BYTE in CMD, ADDR_BYTE in ADDR, buffer[idx] in DATA, and the checksum in CSUM.
REQ-023 The FSM SHALL go CMD->ADDR->DATA; DATA SHALL push idx 0..NBYTES-1 in order, with idx a 4-bit counter cleared on DATA entry.
REQ-024 After the last frame byte is pushed, the FSM SHALL return to IDLE, busy SHALL fall and done SHALL be 1 for exactly one cycle, all on the same edge.
REQ-025 A frame SHALL be exactly NBYTES+2 pushes (NBYTES+3 with checksum), with no gaps while full=0; minimum frame time is NBYTES+2 cycles.
REQ-026 If start=1 coincides with the done edge, it SHALL be ignored, because the FSM is not yet IDLE on that edge.
REQ-027 A buffer write in the same cycle as an accepted start SHALL take effect and be sent in that frame.
REQ-028 full toggling mid-frame SHALL cause no loss, duplication or reordering of bytes.

Reset
REQ-029 While rst=0, the block SHALL force, asynchronously: state=IDLE, idx=0, busy=0, done=0, buf_err=0, write=0, data=8'h00 and all buffer bytes=8'h00.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately; no further pushes SHALL occur until a new start after rst=1.

Configuration
REQ-031 With macro SPI_FRAME_SEQ_CHECKSUM_EN defined, DATA SHALL go to CSUM, which pushes the XOR of CMD_BYTE, ADDR_BYTE and all NBYTES data bytes; without the macro, DATA SHALL go straight to IDLE and no CSUM state or XOR logic SHALL exist.

Verification
REQ-032 Write buffer 0..7 = 01..08, start, full=0 -> write high 10 consecutive cycles with data 40,C0,01..08, then done pulse, busy low.
REQ-033 Same as REQ-032 with full=1 for 3 cycles during idx=2 -> byte 03 held, sequence identical, frame length 13 cycles.
REQ-034 buf_we with addr=9, and buf_we during busy -> buf_err pulses each time, buffer unchanged, next frame carries old data.
REQ-035 rst=0 during idx=4 -> write=0 immediately, busy=0, buffer reads back 00; a new start after reset emits 40,C0,00x8.
REQ-036 SPI_FRAME_SEQ_CHECKSUM_EN defined, buffer=01..08 -> 11 pushes ending with 40^C0^08=88; start asserted on the done edge is ignored.

Source files
------------

// File: rtl/spi_frame_seq.sv
// rtl/spi_frame_seq.sv - frame sequencer pushing CMD, ADDR and NBYTES buffered data bytes into an SPI FIFO
// Optional trailing XOR checksum byte when SPI_FRAME_SEQ_CHECKSUM_EN is defined.
module spi_frame_seq #(
   parameter int         NBYTES    = 8,
   parameter logic [7:0] CMD_BYTE  = 8'h40,
   parameter logic [7:0] ADDR_BYTE = 8'hC0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       buf_we,
   input  logic [3:0] buf_addr,
   input  logic [7:0] buf_wdata,
   input  logic       start,
   input  logic       full,
   output logic       write,
   output logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       buf_err
);

   localparam logic [4:0] NB_LIM   = 5'(NBYTES);
   localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
      DATA,
      CSUM
`else
      DATA
`endif
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] idx, idx_nxt;
   logic       done_nxt;
   logic [7:0] buf_mem [NBYTES];
   logic [7:0] buf_byte;
   logic       buf_ok;
   logic       buf_reject;

   assign busy       = (state != IDLE);
   assign write      = busy && !full;
   assign buf_ok     = buf_we && !busy && ({1'b0, buf_addr} < NB_LIM);
   assign buf_reject = buf_we && !buf_ok;

   // Compare-based read mux keeps the 4-bit idx independent of NBYTES.
   always_comb begin
      buf_byte = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx == 4'(i)) buf_byte = buf_mem[i];
      end
   end

`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
   logic [7:0] csum;

   always_comb begin
      csum = CMD_BYTE ^ ADDR_BYTE;
      for (int i = 0; i < NBYTES; i++) begin
         csum = csum ^ buf_mem[i];
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      done_nxt  = 1'b0;
      data      = 8'h00;
      case (state)
         IDLE: begin
            if (start) state_nxt = CMD;
         end
         CMD: begin
            data = CMD_BYTE;
            if (write) state_nxt = ADDR;
         end
         ADDR: begin
            data = ADDR_BYTE;
            if (write) begin
               state_nxt = DATA;
               idx_nxt   = 4'd0;
            end
         end
         DATA: begin
            data = buf_byte;
            if (write) begin
               if (idx == LAST_IDX) begin
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
                  state_nxt = CSUM;
`else
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
`endif
               end else begin
                  idx_nxt = idx + 4'd1;
               end
            end
         end
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
         CSUM: begin
            data = csum;
            if (write) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         idx     <= 4'd0;
         done    <= 1'b0;
         buf_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         done    <= done_nxt;
         buf_err <= buf_reject;
      end
   end

   // Buffer is frozen while busy, so the frame and checksum see stable bytes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NBYTES; i++) buf_mem[i] <= 8'h00;
      end else if (buf_ok) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (buf_addr == 4'(i)) buf_mem[i] <= buf_wdata;
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_seq.sv
// tb/tb_spi_frame_seq.sv - directed self-checking bench for spi_frame_seq
module tb_spi_frame_seq;

   localparam int NB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       buf_we;
   logic [3:0] buf_addr;
   logic [7:0] buf_wdata;
   logic       start;
   logic       full;
   logic       write;
   logic [7:0] data;
   logic       busy;
   logic       done;
   logic       buf_err;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [7:0] model [0:NB-1];
   logic [7:0] got   [0:31];

   spi_frame_seq #(.NBYTES(NB), .CMD_BYTE(8'h40), .ADDR_BYTE(8'hC0)) dut (
      .clk       (clk),
      .rst       (rst),
      .buf_we    (buf_we),
      .buf_addr  (buf_addr),
      .buf_wdata (buf_wdata),
      .start     (start),
      .full      (full),
      .write     (write),
      .data      (data),
      .busy      (busy),
      .done      (done),
      .buf_err   (buf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // One buffer write; returns 2 time units after the write edge so buf_err is visible.
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      buf_we    = 1'b1;
      buf_addr  = a;
      buf_wdata = d;
      step();
      buf_we = 1'b0;
   endtask

   task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                            input bit start_on_last);
      logic [7:0] exp_b [0:31];
      int         exp_n;
      int         n       = 0;
      int         cyc     = 0;
      int         stalled = 0;
      bit         seen    = 1'b0;
      exp_b[0] = 8'h40;
      exp_b[1] = 8'hC0;
      for (int i = 0; i < NB; i++) exp_b[2+i] = model[i];
      exp_n = NB + 2;
`ifdef SPI_FRAME_SEQ_CHECKSUM_EN
      exp_b[exp_n] = 8'h40 ^ 8'hC0;
      for (int i = 0; i < NB; i++) exp_b[exp_n] = exp_b[exp_n] ^ model[i];
      exp_n++;
`endif
      for (int i = 0; i < 32; i++) got[i] = 8'hxx;
      start = 1'b1;
      step();
      start  = 1'b0;
      buf_we = 1'b0;
      check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
      while (!seen && cyc < 200) begin
         if (n == stall_at && stalled < stall_len) begin
            full = 1'b1;
            stalled++;
         end else begin
            full = 1'b0;
         end
         start = (start_on_last && n == exp_n - 1 && !full);
         #1;
         if (write) begin
            if (n < 32) got[n] = data;
            n++;
         end
         step();
         start = 1'b0;
         cyc++;
         if (done) seen = 1'b1;
      end
      full = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_push_count"}, 32'(n), 32'(exp_n));
      check({tag, "_frame_cycles"}, 32'(cyc), 32'(exp_n + stall_len));
      for (int i = 0; i < exp_n; i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_b[i]));
      step();
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_idle_after"}, {30'd0, busy, write}, 32'd0);
   endtask

   initial begin
      int k;
      rst       = 1'b0;
      buf_we    = 1'b0;
      buf_addr  = 4'd0;
      buf_wdata = 8'h00;
      start     = 1'b0;
      full      = 1'b0;
      #12;
      check("rst_write", 32'(write), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_buf_err", 32'(buf_err), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      step();
      rst = 1'b1;
      step();

      for (int i = 0; i < NB; i++) begin
         model[i] = 8'(i + 1);
         wr(4'(i), 8'(i + 1));
         check($sformatf("fill_err%0d", i), 32'(buf_err), 32'd0);
      end

      run_frame("basic", -1, 0, 1'b0);
      run_frame("stall", 4, 3, 1'b0);

      wr(4'd9, 8'hEE);
      check("oob_err", 32'(buf_err), 32'd1);
      step();
      check("oob_err_clear", 32'(buf_err), 32'd0);

      start = 1'b1;
      step();
      start     = 1'b0;
      buf_we    = 1'b1;
      buf_addr  = 4'd0;
      buf_wdata = 8'hFF;
      step();
      buf_we = 1'b0;
      check("busy_wr_err", 32'(buf_err), 32'd1);
      k = 0;
      while (!done && k < 50) begin
         step();
         k++;
      end
      check("busy_wr_frame_done", 32'(done), 32'd1);
      step();
      run_frame("old_data", -1, 0, 1'b0);

      buf_we    = 1'b1;
      buf_addr  = 4'd7;
      buf_wdata = 8'h5A;
      model[7]  = 8'h5A;
      run_frame("wr_with_start", -1, 0, 1'b0);

      run_frame("start_on_done", -1, 0, 1'b1);

      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("mid_data_idx4", 32'(data), 32'(model[4]));
      rst = 1'b0;
      #1;
      check("mid_rst_write", 32'(write), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_data", 32'(data), 32'd0);
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_rst_quiet%0d", i), {30'd0, busy, write}, 32'd0);
      end
      for (int i = 0; i < NB; i++) model[i] = 8'h00;
      run_frame("after_rst", -1, 0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
